qsn_merge_pipe: RTL



---
 rtl/qsn_pkg.sv | 34 +++
 rtl/qsn_merge_pipe_if.sv | 41 ++++
 rtl/qsn_merge_sel_dec.sv | 33 +++
 rtl/qsn_merge_pipe.sv | 106 ++++++++++
 4 files changed

// File: rtl/qsn_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : qsn_pkg
//  Description : Shared constants and the shift-to-select reference function
//                for the QSN merge stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package qsn_pkg;

  localparam int DEF_Z     = 15;
  localparam int DEF_MSG_W = 4;
  localparam int MIN_Z     = 2;
  localparam int MAX_Z     = 64;
  localparam int SEL_MAX_W = MAX_Z - 1;

  // Lane k of a packed vector starts at bit k*w.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

  // Bit i is set iff i < effective shift; out-of-range shifts select nothing.
  function automatic logic [SEL_MAX_W-1:0] sel_vec(input int shift, input int z);
    logic [SEL_MAX_W-1:0] v;
    int                   eff;
    eff = (shift < z) ? shift : 0;
    v   = '0;
    for (int i = 0; i < SEL_MAX_W; i++) begin
      v[i] = (i < z - 1) && (i < eff);
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qsn_merge_pipe_if.sv
`default_nettype none
// ============================================================================
//  Interface   : qsn_merge_pipe_if
//  Description : Upstream and downstream handshake bundle of the QSN merge stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface qsn_merge_pipe_if
  import qsn_pkg::*;
#(
  parameter int Z       = DEF_Z,
  parameter int MSG_W   = DEF_MSG_W,
  parameter int SHIFT_W = $clog2(Z),
  parameter int TAG_W   = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [(Z-1)*MSG_W-1:0] left_in;
  logic [Z*MSG_W-1:0]     right_in;
  logic [SHIFT_W-1:0]     shift;
  logic [TAG_W-1:0]       tag_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [Z*MSG_W-1:0]     sw_out;
  logic [TAG_W-1:0]       tag_out;
  logic                   shift_err;

  // Pipeline side.
  modport slave (
    input  in_valid, left_in, right_in, shift, tag_in, out_ready,
    output in_ready, out_valid, sw_out, tag_out, shift_err
  );

  // Producer / consumer side.
  modport master (
    output in_valid, left_in, right_in, shift, tag_in, out_ready,
    input  in_ready, out_valid, sw_out, tag_out, shift_err
  );

endinterface
`default_nettype wire

// File: rtl/qsn_merge_sel_dec.sv
`default_nettype none
// ============================================================================
//  Module      : qsn_merge_sel_dec
//  Description : Shift factor to thermometer lane-select decoder with range check.
//  Revision    : 1.0 - initial release
// ============================================================================
module qsn_merge_sel_dec
  import qsn_pkg::*;
#(
  parameter int Z       = DEF_Z,
  parameter int SHIFT_W = $clog2(Z)
) (
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [Z-2:0]       sel_o,
  output logic               err_o
);

  int w_shift;
  int w_eff;

  always_comb begin
    w_shift = int'(shift_i);
    err_o   = (w_shift >= Z);
    // An illegal shift degrades to shift 0 so the lanes stay well-defined.
    w_eff   = err_o ? 0 : w_shift;
    sel_o   = '0;
    for (int i = 0; i < Z - 1; i++) begin
      sel_o[i] = (i < w_eff);
    end
  end

endmodule
`default_nettype wire

// File: rtl/qsn_merge_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : qsn_merge_pipe
//  Description : Two-stage valid/ready merge of left (Z-1) and right (Z) QSN lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module qsn_merge_pipe
  import qsn_pkg::*;
#(
  parameter int Z       = DEF_Z,
  parameter int MSG_W   = DEF_MSG_W,
  parameter int SHIFT_W = $clog2(Z),
  parameter int TAG_W   = 4
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  qsn_merge_pipe_if.slave      bus
);

  localparam int LW = (Z - 1) * MSG_W;
  localparam int ZW = Z * MSG_W;

  logic [LW-1:0]    left_q;
  logic [ZW-1:0]    right_q;
  logic [Z-2:0]     sel_q;
  logic [TAG_W-1:0] tag1_q;
  logic             err1_q;
  logic             s1_valid_q, s1_valid_d;

  logic [ZW-1:0]    sw_q;
  logic [TAG_W-1:0] tag2_q;
  logic             err2_q;
  logic             s2_valid_q, s2_valid_d;

  logic [Z-2:0]     w_sel;
  logic             w_err;
  logic [ZW-1:0]    w_merged;
  logic             w_s1_en;
  logic             w_s2_en;

  qsn_merge_sel_dec #(
    .Z       (Z),
    .SHIFT_W (SHIFT_W)
  ) u_sel_dec (
    .shift_i (bus.shift),
    .sel_o   (w_sel),
    .err_o   (w_err)
  );

  // A full stage may refill in the same cycle its successor drains it.
  always_comb begin
    w_s2_en    = ~s2_valid_q | bus.out_ready;
    w_s1_en    = ~s1_valid_q | w_s2_en;
    s1_valid_d = bus.in_valid & w_s1_en;
    s2_valid_d = s1_valid_q;
  end

  generate
    for (genvar i = 0; i < Z - 1; i++) begin : g_lane
      localparam int LO_L = lane_lo(i, MSG_W);
      localparam int LO_R = lane_lo(Z - 1 - i, MSG_W);
      assign w_merged[LO_L +: MSG_W] = sel_q[i] ? left_q[LO_L +: MSG_W]
                                                : right_q[LO_R +: MSG_W];
    end : g_lane
  endgenerate

  assign w_merged[(Z-1)*MSG_W +: MSG_W] = right_q[0 +: MSG_W];

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      left_q     <= '0;
      right_q    <= '0;
      sel_q      <= '0;
      tag1_q     <= '0;
      err1_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      sw_q       <= '0;
      tag2_q     <= '0;
      err2_q     <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (w_s1_en) begin
        left_q     <= bus.left_in;
        right_q    <= bus.right_in;
        sel_q      <= w_sel;
        tag1_q     <= bus.tag_in;
        err1_q     <= w_err;
        s1_valid_q <= s1_valid_d;
      end
      if (w_s2_en) begin
        sw_q       <= w_merged;
        tag2_q     <= tag1_q;
        err2_q     <= err1_q;
        s2_valid_q <= s2_valid_d;
      end
    end
  end

  assign bus.in_ready  = w_s1_en;
  assign bus.out_valid = s2_valid_q;
  assign bus.sw_out    = sw_q;
  assign bus.tag_out   = tag2_q;
  assign bus.shift_err = err2_q;

endmodule
`default_nettype wire
